regfile_wb_ctrl: RTL and testbench

//   Write-back controller for the register file (6 accumulators, 4 regular, flag bit).

---
 rtl/regfile_wb_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_regfile_wb_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl
//   Write-back controller for the register file (accumulators, regular registers, flag bit).
//   Arbitrates the single register-file write port between the ALU (requester A) and the load
//   unit (requester B), registers the granted payload for one cycle and drives the register-file
//   write controls. A busy scoreboard tracks registers with outstanding writes and stalls decode
//   on RAW/WAW hazards.
//
// Configuration macro:
//   RF_WB_FIXED_PRIO_EN  defined   -> fixed priority, B (load) always wins over A.
//                        undefined -> round-robin between A and B (default build).
//
// Ports:
//   CLK, RESET              clock (rising edge), asynchronous active-high reset
//   iss_*                   decode issue: valid, destination (+isReg, wdst), two sources (+isReg)
//   stall                   hazard, decode must hold; issue accepted = iss_valid & !stall
//   a_valid/a_ready, a_*    ALU write-back request: reg, isReg, data, wen, fen, flag
//   b_valid/b_ready, b_*    load write-back request: reg, isReg, data (never writes the flag)
//   isWrite, writeReg,
//   writeData, isRegW,
//   flagin, writeFlag       register-file write controls, driven the cycle after a grant
//   wb_err                  sticky: a data write committed to a tracked register not marked busy
module regfile_wb_ctrl #(
  parameter int unsigned NUM_ACC = 6,
  parameter int unsigned NUM_REG = 4,
  parameter int unsigned DW      = 8
) (
  input  logic          CLK,
  input  logic          RESET,
  // Decode issue
  input  logic          iss_valid,
  input  logic [2:0]    iss_dst,
  input  logic          iss_dst_isReg,
  input  logic          iss_wdst,
  input  logic [2:0]    iss_src1,
  input  logic          iss_src1_isReg,
  input  logic [2:0]    iss_src2,
  input  logic          iss_src2_isReg,
  output logic          stall,
  // Requester A (ALU)
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [2:0]    a_reg,
  input  logic          a_isReg,
  input  logic [DW-1:0] a_data,
  input  logic          a_wen,
  input  logic          a_fen,
  input  logic          a_flag,
  // Requester B (load unit)
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [2:0]    b_reg,
  input  logic          b_isReg,
  input  logic [DW-1:0] b_data,
  // Register-file write port
  output logic          isWrite,
  output logic [2:0]    writeReg,
  output logic [DW-1:0] writeData,
  output logic          isRegW,
  output logic          flagin,
  output logic          writeFlag,
  output logic          wb_err
);

  localparam int unsigned NumBits = NUM_ACC + NUM_REG;

  // One-hot scoreboard bit for a register; accumulators beyond NUM_ACC map to no bit at all.
  function automatic logic [NumBits-1:0] regMask(input logic [2:0] idx, input logic isReg);
    logic [NumBits-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_ACC; i++) begin
      if (!isReg && idx == i[2:0]) m[i] = 1'b1;
    end
    for (int i = 0; i < NUM_REG; i++) begin
      if (isReg && idx[1:0] == i[1:0]) m[NUM_ACC + i] = 1'b1;
    end
    return m;
  endfunction

  logic [NumBits-1:0] busyQ, busyD;
  logic [NumBits-1:0] srcMask, dstMask, setMask, commitMask;
  logic               errD;
  logic               aGrant, bGrant;
  logic               issueAccept;

  // ---------------------------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    srcMask = regMask(iss_src1, iss_src1_isReg) | regMask(iss_src2, iss_src2_isReg);
    dstMask = regMask(iss_dst, iss_dst_isReg);
    stall   = iss_valid & ~RESET &
              ((|(busyQ & srcMask)) | (iss_wdst & (|(busyQ & dstMask))));
    issueAccept = iss_valid & ~stall;
  end

  // ---------------------------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------------------------
`ifdef RF_WB_FIXED_PRIO_EN
  always_comb begin
    bGrant = b_valid;
    aGrant = a_valid & ~b_valid;
  end
`else
  localparam logic PtrA = 1'b0;
  localparam logic PtrB = 1'b1;

  logic rrPtrQ, rrPtrD;

  always_comb begin
    if (a_valid && b_valid) begin
      aGrant = (rrPtrQ == PtrA);
      bGrant = (rrPtrQ == PtrB);
    end else begin
      aGrant = a_valid;
      bGrant = b_valid;
    end
    // Pointer flips to the side that did not just win.
    rrPtrD = rrPtrQ;
    if (a_ready)      rrPtrD = PtrB;
    else if (b_ready) rrPtrD = PtrA;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) rrPtrQ <= PtrA;
    else       rrPtrQ <= rrPtrD;
  end
`endif

  assign a_ready = aGrant & ~RESET;
  assign b_ready = bGrant & ~RESET;

  // ---------------------------------------------------------------------------------------------
  // Output stage: granted payload is registered and drives the register file for one cycle
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      isWrite   <= 1'b0;
      writeReg  <= '0;
      writeData <= '0;
      isRegW    <= 1'b0;
      flagin    <= 1'b0;
      writeFlag <= 1'b0;
    end else if (a_ready) begin
      isWrite   <= a_wen;
      writeReg  <= a_reg;
      writeData <= a_data;
      isRegW    <= a_isReg;
      flagin    <= a_flag;
      writeFlag <= a_fen;
    end else if (b_ready) begin
      isWrite   <= 1'b1;
      writeReg  <= b_reg;
      writeData <= b_data;
      isRegW    <= b_isReg;
      flagin    <= 1'b0;
      writeFlag <= 1'b0;
    end else begin
      // Payload fields hold; only the strobes matter when idle.
      isWrite   <= 1'b0;
      writeFlag <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Scoreboard and write-back error
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    commitMask = isWrite ? regMask(writeReg, isRegW) : '0;
    setMask    = (issueAccept && iss_wdst) ? regMask(iss_dst, iss_dst_isReg) : '0;
    // Set is applied after clear so a same-edge set wins.
    busyD      = (busyQ & ~commitMask) | setMask;
    // Untracked registers (no scoreboard bit) cannot raise the error.
    errD       = wb_err | ((|commitMask) & ~(|(busyQ & commitMask)));
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      busyQ  <= '0;
      wb_err <= 1'b0;
    end else begin
      busyQ  <= busyD;
      wb_err <= errD;
    end
  end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
module tb_regfile_wb_ctrl;

  logic       CLK;
  logic       RESET;
  logic       iss_valid, iss_dst_isReg, iss_wdst, iss_src1_isReg, iss_src2_isReg;
  logic [2:0] iss_dst, iss_src1, iss_src2;
  logic       stall;
  logic       a_valid, a_ready, a_isReg, a_wen, a_fen, a_flag;
  logic [2:0] a_reg;
  logic [7:0] a_data;
  logic       b_valid, b_ready, b_isReg;
  logic [2:0] b_reg;
  logic [7:0] b_data;
  logic       isWrite, isRegW, flagin, writeFlag, wb_err;
  logic [2:0] writeReg;
  logic [7:0] writeData;

  regfile_wb_ctrl #(.NUM_ACC(6), .NUM_REG(4), .DW(8)) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .iss_valid      (iss_valid),
    .iss_dst        (iss_dst),
    .iss_dst_isReg  (iss_dst_isReg),
    .iss_wdst       (iss_wdst),
    .iss_src1       (iss_src1),
    .iss_src1_isReg (iss_src1_isReg),
    .iss_src2       (iss_src2),
    .iss_src2_isReg (iss_src2_isReg),
    .stall          (stall),
    .a_valid        (a_valid),
    .a_ready        (a_ready),
    .a_reg          (a_reg),
    .a_isReg        (a_isReg),
    .a_data         (a_data),
    .a_wen          (a_wen),
    .a_fen          (a_fen),
    .a_flag         (a_flag),
    .b_valid        (b_valid),
    .b_ready        (b_ready),
    .b_reg          (b_reg),
    .b_isReg        (b_isReg),
    .b_data         (b_data),
    .isWrite        (isWrite),
    .writeReg       (writeReg),
    .writeData      (writeData),
    .isRegW         (isRegW),
    .flagin         (flagin),
    .writeFlag      (writeFlag),
    .wb_err         (wb_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       isW;
    logic [2:0] wReg;
    logic [7:0] data;
    logic       regW;
    logic       flag;
    logic       wFlag;
  } wbExp_t;

  localparam wbExp_t Idle = '{isW: 1'b0, wReg: 3'd0, data: 8'h00, regW: 1'b0, flag: 1'b0,
                              wFlag: 1'b0};

  wbExp_t expQ[$];
  logic   rrModel;  // 0 = A next on contention
  int     nChecks = 0;
  int     nErrors = 0;
  logic   gA, gB;
  int     bIdx;
  logic [1:0] expAB;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp)
    else begin
      nErrors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkStall(input logic exp);
    #1;
    chk("stall", {31'd0, stall}, {31'd0, exp});
  endtask

  // One clock cycle: compare the write port against the scoreboard, check the grant against the
  // arbitration model, and queue what the write port must show next cycle.
  task automatic tick(output logic grantA, output logic grantB);
    wbExp_t e, n;
    @(negedge CLK);
    if (expQ.size() == 0) e = Idle;
    else                  e = expQ.pop_front();
    chk("isWrite", {31'd0, isWrite}, {31'd0, e.isW});
    chk("writeFlag", {31'd0, writeFlag}, {31'd0, e.wFlag});
    if (e.isW || e.wFlag) begin
      chk("writeReg", {29'd0, writeReg}, {29'd0, e.wReg});
      chk("isRegW", {31'd0, isRegW}, {31'd0, e.regW});
      if (e.isW)   chk("writeData", {24'd0, writeData}, {24'd0, e.data});
      if (e.wFlag) chk("flagin", {31'd0, flagin}, {31'd0, e.flag});
    end
`ifdef RF_WB_FIXED_PRIO_EN
    grantB = b_valid;
    grantA = a_valid & ~b_valid;
`else
    if (a_valid && b_valid) begin
      grantA = ~rrModel;
      grantB = rrModel;
    end else begin
      grantA = a_valid;
      grantB = b_valid;
    end
`endif
    chk("a_ready", {31'd0, a_ready}, {31'd0, grantA});
    chk("b_ready", {31'd0, b_ready}, {31'd0, grantB});
    n = Idle;
    if (grantA) begin
      n = '{isW: a_wen, wReg: a_reg, data: a_data, regW: a_isReg, flag: a_flag, wFlag: a_fen};
      rrModel = 1'b1;
    end else if (grantB) begin
      n = '{isW: 1'b1, wReg: b_reg, data: b_data, regW: b_isReg, flag: 1'b0, wFlag: 1'b0};
      rrModel = 1'b0;
    end
    expQ.push_back(n);
    @(posedge CLK);
    #1;
  endtask

  task automatic releaseReset();
    RESET = 1'b0;
    expQ.delete();
    expQ.push_back(Idle);
    rrModel = 1'b0;
  endtask

  task automatic doReset();
    RESET     = 1'b1;
    a_valid   = 1'b0;
    b_valid   = 1'b0;
    iss_valid = 1'b0;
    @(posedge CLK);
    #1;
    releaseReset();
  endtask

  task automatic issue(input logic [2:0] dst, input logic dstR, input logic wdst,
                       input logic [2:0] s1, input logic s1R);
    iss_valid      = 1'b1;
    iss_dst        = dst;
    iss_dst_isReg  = dstR;
    iss_wdst       = wdst;
    iss_src1       = s1;
    iss_src1_isReg = s1R;
    iss_src2       = 3'd0;
    iss_src2_isReg = 1'b0;
  endtask

  task automatic driveA(input logic [2:0] r, input logic [7:0] d, input logic wen,
                        input logic fen, input logic flg);
    a_valid = 1'b1;
    a_reg   = r;
    a_isReg = 1'b0;
    a_data  = d;
    a_wen   = wen;
    a_fen   = fen;
    a_flag  = flg;
  endtask

  initial begin
    RESET = 1'b1;
    iss_valid = 1'b1; iss_dst = '0; iss_dst_isReg = 0; iss_wdst = 1'b1;
    iss_src1 = '0; iss_src1_isReg = 0; iss_src2 = '0; iss_src2_isReg = 0;
    a_valid = 1'b1; a_reg = '0; a_isReg = 0; a_data = '0; a_wen = 1'b1; a_fen = 0; a_flag = 0;
    b_valid = 1'b1; b_reg = '0; b_isReg = 0; b_data = '0;
    rrModel = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    // Reset state, with requests and an issue presented
    chk("rst_isWrite", {31'd0, isWrite}, 32'd0);
    chk("rst_writeReg", {29'd0, writeReg}, 32'd0);
    chk("rst_writeData", {24'd0, writeData}, 32'd0);
    chk("rst_isRegW", {31'd0, isRegW}, 32'd0);
    chk("rst_flagin", {31'd0, flagin}, 32'd0);
    chk("rst_writeFlag", {31'd0, writeFlag}, 32'd0);
    chk("rst_wb_err", {31'd0, wb_err}, 32'd0);
    chk("rst_a_ready", {31'd0, a_ready}, 32'd0);
    chk("rst_b_ready", {31'd0, b_ready}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    a_valid = 0; b_valid = 0; iss_valid = 0;
    releaseReset();

    // RAW hazard on acc2, cleared by an ALU write
    issue(3'd2, 1'b0, 1'b1, 3'd0, 1'b0); chkStall(1'b0); tick(gA, gB);
    issue(3'd0, 1'b0, 1'b0, 3'd2, 1'b0); chkStall(1'b1); tick(gA, gB);
    chkStall(1'b1); tick(gA, gB);
    driveA(3'd2, 8'h5A, 1'b1, 1'b0, 1'b0); chkStall(1'b1); tick(gA, gB);
    a_valid = 1'b0; chkStall(1'b1); tick(gA, gB);   // write port shows acc2 = 5A
    chkStall(1'b0);
    chk("wb_err_raw", {31'd0, wb_err}, 32'd0);
    iss_valid = 1'b0; tick(gA, gB);

    // Contention from reset; r0..r3 marked busy first so load commits are legal
    doReset();
    for (int i = 0; i < 4; i++) begin
      issue(i[2:0], 1'b1, 1'b1, 3'd0, 1'b0); chkStall(1'b0); tick(gA, gB);
    end
    iss_valid = 1'b0;
    driveA(3'd5, 8'h00, 1'b0, 1'b0, 1'b0);
    bIdx = 0; b_valid = 1'b1; b_isReg = 1'b1; b_reg = 3'd0; b_data = 8'hB0;
    for (int k = 0; k < 4; k++) begin
`ifdef RF_WB_FIXED_PRIO_EN
      expAB = 2'b01;
`else
      expAB = (k % 2 == 0) ? 2'b10 : 2'b01;
`endif
      #1;
      chk("arbOrder", {30'd0, a_ready, b_ready}, {30'd0, expAB});
      tick(gA, gB);
      if (gB) begin
        bIdx++;
        b_reg  = bIdx[2:0];
        b_data = 8'hB0 + bIdx[7:0];
      end
    end
    a_valid = 1'b0; b_valid = 1'b0;
    tick(gA, gB);
    chk("wb_err_arb", {31'd0, wb_err}, 32'd0);

    // Load write to regular r3 clears busy bit 9
    doReset();
    issue(3'd3, 1'b1, 1'b1, 3'd0, 1'b0); chkStall(1'b0); tick(gA, gB);
    issue(3'd0, 1'b0, 1'b0, 3'd3, 1'b1);
    b_valid = 1'b1; b_reg = 3'd3; b_isReg = 1'b1; b_data = 8'hC3;
    chkStall(1'b1); tick(gA, gB);
    b_valid = 1'b0; chkStall(1'b1); tick(gA, gB);   // write port shows r3 = C3
    chkStall(1'b0);
    chk("wb_err_r3", {31'd0, wb_err}, 32'd0);
    iss_valid = 1'b0;

    // Flag-only write from the ALU
    driveA(3'd0, 8'h00, 1'b0, 1'b1, 1'b1); tick(gA, gB);
    a_valid = 1'b0; tick(gA, gB);
    chk("wb_err_flag", {31'd0, wb_err}, 32'd0);

    // Same-edge set and clear of acc4: set wins
    driveA(3'd4, 8'h44, 1'b1, 1'b0, 1'b0); tick(gA, gB);
    a_valid = 1'b0;
    issue(3'd4, 1'b0, 1'b1, 3'd0, 1'b0); chkStall(1'b0); tick(gA, gB);
    issue(3'd0, 1'b0, 1'b0, 3'd4, 1'b0); chkStall(1'b1);
    chk("wb_err_acc4", {31'd0, wb_err}, 32'd1);
    tick(gA, gB);
    chkStall(1'b1);
    iss_valid = 1'b0;
    tick(gA, gB);

    // Commit to idle acc1 raises sticky wb_err; acc7 is never tracked
    doReset();
    chk("wb_err_clr", {31'd0, wb_err}, 32'd0);
    driveA(3'd1, 8'h11, 1'b1, 1'b0, 1'b0); tick(gA, gB);
    a_valid = 1'b0;
    chk("wb_err_pre", {31'd0, wb_err}, 32'd0);
    tick(gA, gB);
    chk("wb_err_set", {31'd0, wb_err}, 32'd1);
    tick(gA, gB); tick(gA, gB);
    chk("wb_err_hold", {31'd0, wb_err}, 32'd1);
    issue(3'd7, 1'b0, 1'b1, 3'd0, 1'b0); chkStall(1'b0); tick(gA, gB);
    issue(3'd7, 1'b0, 1'b1, 3'd7, 1'b0); chkStall(1'b0); tick(gA, gB);
    iss_valid = 1'b0;

    // Reset while a grant is staged
    issue(3'd3, 1'b0, 1'b1, 3'd0, 1'b0); tick(gA, gB);
    iss_valid = 1'b0;
    driveA(3'd3, 8'h33, 1'b1, 1'b0, 1'b0); tick(gA, gB);
    a_valid = 1'b0;
    chk("staged_isWrite", {31'd0, isWrite}, 32'd1);
    RESET = 1'b1;
    #1;
    chk("rstmid_isWrite", {31'd0, isWrite}, 32'd0);
    chk("rstmid_wb_err", {31'd0, wb_err}, 32'd0);
    chk("rstmid_writeFlag", {31'd0, writeFlag}, 32'd0);
    @(posedge CLK);
    #1;
    releaseReset();
    issue(3'd0, 1'b0, 1'b0, 3'd3, 1'b0); chkStall(1'b0);
    iss_valid = 1'b0;
    driveA(3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
    b_valid = 1'b1; b_reg = 3'd0; b_isReg = 1'b1; b_data = 8'hEE;
`ifdef RF_WB_FIXED_PRIO_EN
    expAB = 2'b01;
`else
    expAB = 2'b10;
`endif
    #1;
    chk("firstGrant", {30'd0, a_ready, b_ready}, {30'd0, expAB});
    tick(gA, gB);
    a_valid = 1'b0; b_valid = 1'b0;
    tick(gA, gB);
    tick(gA, gB);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

  // Global bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
